tx_arbiter_break: RTL

//  Parametrised transmit front-end for the terminal's PC UART. Merges N byte

---
 rtl/tx_arbiter_break.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/tx_arbiter_break.sv
// Purpose: merge CHANNELS byte sources into one UART TX stream with RR arbitration and line-break generation.
// Latency: a byte pushed into an empty FIFO at edge N is presented on o_m_valid after edge N+1.
// Backpressure: o_s_ready drops when a channel FIFO is full; o_m_data holds until i_m_ready; breaks wait for the line to drain.
module tx_arbiter_break #(
  parameter int CHANNELS     = 2,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int BREAK_CYCLES = 24000,
  parameter int GUARD_CYCLES = 1200
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [CHANNELS*DATA_W-1:0] i_s_data,
  input  logic [CHANNELS-1:0]        i_s_valid,
  output logic [CHANNELS-1:0]        o_s_ready,
  input  logic [CHANNELS-1:0]        i_break_req,
  output logic [DATA_W-1:0]          o_m_data,
  output logic                       o_m_valid,
  input  logic                       i_m_ready,
  input  logic                       i_tx_busy,
  output logic                       o_break,
  output logic                       o_break_busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int MAX_C  = (BREAK_CYCLES > GUARD_CYCLES) ? BREAK_CYCLES : GUARD_CYCLES;
  localparam int CNT_BW = $clog2(MAX_C + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_BREAK,
    ST_GUARD
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_BW-1:0]   cnt;
  logic [CNT_BW-1:0]   cnt_nxt;
  logic                pend;
  logic                pend_nxt;
  logic                any_req;

  logic [CHANNELS-1:0] empty;
  logic [DATA_W-1:0]   head_dat [CHANNELS];
  logic [IDX_W-1:0]    last_grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_vld;
  logic [IDX_W-1:0]    cand_idx;
  int                  cand_sum;
  logic                load;

  assign any_req = |i_break_req;

  // Output loads only while idle, when the holding register is free or being emptied this cycle.
  assign load = (state == ST_IDLE) && (!o_m_valid || i_m_ready) && grant_vld;

  // Per-channel FIFO: registered count gives o_s_ready; the head entry is read combinationally.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    assign o_s_ready[k] = (count != CNT_W'(FIFO_DEPTH));
    assign empty[k]     = (count == '0);
    assign push         = i_s_valid[k] && o_s_ready[k];
    assign pop          = load && (grant_idx == IDX_W'(k));
    assign head_dat[k]  = mem[rd_ptr];

    // Storage array needs no reset; only written on an accepted push.
    always_ff @(posedge i_clk) begin
      if (push) begin
        mem[wr_ptr] <= i_s_data[k*DATA_W +: DATA_W];
      end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Round-robin pick: first non-empty channel after the last grant, wrapping to 0.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_sum  = 0;
    cand_idx  = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      cand_sum = int'(last_grant) + i;
      if (cand_sum >= CHANNELS) cand_sum = cand_sum - CHANNELS;
      cand_idx = IDX_W'(cand_sum);
      if (!grant_vld && !empty[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Output holding register and RR pointer; reset pointer makes ch0 win first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_m_valid  <= 1'b0;
      o_m_data   <= '0;
      last_grant <= IDX_W'(CHANNELS - 1);
    end else if (load) begin
      o_m_valid  <= 1'b1;
      o_m_data   <= head_dat[grant_idx];
      last_grant <= grant_idx;
    end else if (i_m_ready) begin
      o_m_valid  <= 1'b0;
    end
  end

  // Break sequencer state, counter, pending flag and registered line controls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      pend         <= 1'b0;
      o_break      <= 1'b0;
      o_break_busy <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pend         <= pend_nxt;
      o_break      <= (state_nxt == ST_BREAK);
      o_break_busy <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state: drain the in-flight byte, hold break, then guard; one extra break if requested late.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    case (state)
      ST_IDLE: begin
        if (any_req) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!o_m_valid && !i_tx_busy) begin
          state_nxt = ST_BREAK;
          cnt_nxt   = CNT_BW'(BREAK_CYCLES - 1);
        end
      end
      ST_BREAK: begin
        if (any_req) pend_nxt = 1'b1;
        if (cnt == '0) begin
          state_nxt = ST_GUARD;
          cnt_nxt   = CNT_BW'(GUARD_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CNT_BW'(1);
        end
      end
      ST_GUARD: begin
        if (cnt == '0) begin
          state_nxt = (pend || any_req) ? ST_DRAIN : ST_IDLE;
          pend_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_BW'(1);
          if (any_req) pend_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
